lsu_mem_stage: RTL and testbench

//  Load/store unit directly downstream of the ALU: consumes ALU res as the effective address.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_mem_stage.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared constants, error codes, FSM encoding and access classifier
//            for the load/store memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Illegal takes priority over misaligned; funct3[1:0] encodes access size.
    function automatic logic [1:0] classify_access(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] addr_lo
    );
        logic ld_ok;
        logic st_ok;
        ld_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
        st_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if ((rd && wr) || (rd && !ld_ok) || (wr && !st_ok)) begin
            classify_access = ERR_ILLEGAL;
        end else if (((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00))) begin
            classify_access = ERR_MISALIGN;
        end else begin
            classify_access = ERR_OK;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-lane steering: store enables/replicated data
//            and load byte/half selection with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rs2[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_rs2;
            end
        endcase
    end

    always_comb begin
        o_load_data = 32'h0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : Load/store stage running a req/ack memory transaction with
//            legality checks, bus timeout and CPU stall generation.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic [1:0]  err
);

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_timeout = CW'(TIMEOUT);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_addr;
    logic [31:0]    r_rs2;
    logic [2:0]     r_f3;
    logic           r_we;
    logic [31:0]    r_rdata;
    logic [1:0]     r_err;
    logic [CW-1:0]  r_cnt;

    logic           w_go;
    logic [1:0]     w_chk;
    logic           w_expired;
    logic           w_in_req;
    logic           w_in_done;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_load;

    assign w_go      = valid & (mem_r | mem_w);
    assign w_chk     = classify_access(mem_r, mem_w, funct3, alu_res[1:0]);
    assign w_expired = (r_cnt == c_timeout);
    assign w_in_req  = (r_state == REQ);
    assign w_in_done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_rs2   <= 32'h0;
            r_f3    <= 3'b000;
            r_we    <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= ERR_OK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_go) begin
                        r_addr  <= alu_res;
                        r_rs2   <= rs2_data;
                        r_f3    <= funct3;
                        r_we    <= mem_w;
                        r_rdata <= 32'h0;
                        r_err   <= w_chk;
                    end
                end
                REQ: begin
                    // A late ack on the final counted cycle still completes cleanly.
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_err   <= ERR_OK;
                    end else if (w_expired) begin
                        r_err   <= ERR_TIMEOUT;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt = (w_chk == ERR_OK) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_ack || w_expired) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    lsu_align u_align (
        .i_funct3    (r_f3),
        .i_addr_lo   (r_addr[1:0]),
        .i_rs2       (r_rs2),
        .i_rdata     (r_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load)
    );

    // Bus outputs are forced low outside REQ so nothing leaks while idle.
    assign mem_req   = w_in_req;
    assign mem_we    = w_in_req & r_we;
    assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_be    = w_in_req ? w_be : 4'b0000;
    assign mem_wdata = (w_in_req && r_we) ? w_wdata : 32'h0;

    assign done      = w_in_done;
    assign err       = w_in_done ? r_err : ERR_OK;
    assign load_data = (w_in_done && !r_we && (r_err == ERR_OK)) ? w_load : 32'h0;
    assign stall     = w_go & ~w_in_done;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Brief    : Directed table-driven bench for lsu_mem_stage (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_r, mem_w, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] alu_res, rs2_data, mem_rdata;
    logic        mem_req, mem_we, done, stall;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;
    logic [1:0]  err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .funct3    (funct3),
        .alu_res   (alu_res),
        .rs2_data  (rs2_data),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .load_data (load_data),
        .done      (done),
        .stall     (stall),
        .err       (err)
    );

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_dly;
        int          req_cyc;
        int          done_cyc;
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(
        input logic mr, input logic mw, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
        input int ack_dly, input int req_cyc, input int done_cyc,
        input logic [31:0] waddr, input logic [3:0] be, input logic [31:0] wdata,
        input logic [31:0] ld, input logic [1:0] e
    );
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
        v.rdata = rdata; v.ack_dly = ack_dly; v.req_cyc = req_cyc;
        v.done_cyc = done_cyc; v.waddr = waddr; v.be = be; v.wdata = wdata;
        v.ld = ld; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = 3'b000;
        alu_res = 32'h0; rs2_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        int  nreq;
        bit  seen;
        @(negedge clk);
        valid = 1'b1; mem_r = v.mr; mem_w = v.mw; funct3 = v.f3;
        alu_res = v.addr; rs2_data = v.rs2; mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("stall_issue", idx, {31'h0, stall}, 32'h1);
        cyc = 0; nreq = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    chk("addr", idx, mem_addr, v.waddr);
                    chk("we", idx, {31'h0, mem_we}, {31'h0, v.mw});
                    if (v.mw) begin
                        chk("be", idx, {28'h0, mem_be}, {28'h0, v.be});
                        chk("wdata", idx, mem_wdata, v.wdata);
                    end
                end
                mem_ack   = (cyc - 1 == v.ack_dly);
                mem_rdata = mem_ack ? v.rdata : 32'hDEAD_BEEF;
            end
        end
        chk("done_cycle", idx, cyc, v.done_cyc);
        chk("req_cycles", idx, nreq, v.req_cyc);
        chk("err", idx, {30'h0, err}, {30'h0, v.err});
        chk("load_data", idx, load_data, v.ld);
        chk("stall_done", idx, {31'h0, stall}, 32'h0);
        chk("req_done", idx, {31'h0, mem_req}, 32'h0);
        idle_inputs();
        n_vec++;
    endtask

    initial begin
        //            mr    mw    f3      addr        rs2          rdata        ack rq dn  waddr       be       wdata         ld           err
        tbl[0]  = mk(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,        1, 2, 3, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0,        2'b00);
        tbl[1]  = mk(1'b1, 1'b0, 3'b000, 32'h101, 32'h0,         32'h0000_80FF, 0, 1, 2, 32'h100, 4'b0000, 32'h0,        32'hFFFF_FF80, 2'b00);
        tbl[2]  = mk(1'b1, 1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_80FF, 0, 1, 2, 32'h100, 4'b0000, 32'h0,        32'h0000_0080, 2'b00);
        tbl[3]  = mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h0,         32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        2'b01);
        tbl[4]  = mk(1'b0, 1'b1, 3'b001, 32'h003, 32'h1234,      32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        2'b01);
        tbl[5]  = mk(1'b1, 1'b0, 3'b001, 32'h200, 32'h0,         32'h0,       99, 5, 6, 32'h200, 4'b0000, 32'h0,        32'h0,        2'b11);
        tbl[6]  = mk(1'b1, 1'b1, 3'b010, 32'h000, 32'h0,         32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[7]  = mk(1'b1, 1'b0, 3'b011, 32'h000, 32'h0,         32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[8]  = mk(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_5678, 32'h0,        0, 1, 2, 32'h100, 4'b1100, 32'h5678_5678, 32'h0,        2'b00);
        tbl[9]  = mk(1'b0, 1'b1, 3'b010, 32'h040, 32'hCAFE_F00D, 32'h0,        0, 1, 2, 32'h040, 4'b1111, 32'hCAFE_F00D, 32'h0,        2'b00);
        tbl[10] = mk(1'b1, 1'b0, 3'b001, 32'h106, 32'h0,         32'h8001_1234, 0, 1, 2, 32'h104, 4'b0000, 32'h0,        32'hFFFF_8001, 2'b00);
        tbl[11] = mk(1'b1, 1'b0, 3'b101, 32'h106, 32'h0,         32'h8001_1234, 0, 1, 2, 32'h104, 4'b0000, 32'h0,        32'h0000_8001, 2'b00);
        tbl[12] = mk(1'b1, 1'b0, 3'b010, 32'h008, 32'h0,         32'h89AB_CDEF, 2, 3, 4, 32'h008, 4'b0000, 32'h0,        32'h89AB_CDEF, 2'b00);
        tbl[13] = mk(1'b0, 1'b1, 3'b000, 32'h010, 32'hFFFF_FF3C, 32'h0,        0, 1, 2, 32'h010, 4'b0001, 32'h3C3C_3C3C, 32'h0,        2'b00);
        tbl[14] = mk(1'b0, 1'b1, 3'b100, 32'h010, 32'h55,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[15] = mk(1'b1, 1'b0, 3'b000, 32'h003, 32'h0,         32'h7F00_0000, 3, 4, 5, 32'h000, 4'b0000, 32'h0,        32'h0000_007F, 2'b00);
        tbl[16] = mk(1'b1, 1'b0, 3'b001, 32'h000, 32'h0,         32'h0000_ABCD, 4, 5, 6, 32'h000, 4'b0000, 32'h0,        32'hFFFF_ABCD, 2'b00);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req",   -1, {31'h0, mem_req}, 32'h0);
        chk("rst_done",  -1, {31'h0, done}, 32'h0);
        chk("rst_stall", -1, {31'h0, stall}, 32'h0);
        chk("rst_err",   -1, {30'h0, err}, 32'h0);
        chk("rst_bus",   -1, mem_addr | mem_wdata | load_data | {28'h0, mem_be} | {31'h0, mem_we}, 32'h0);
        n_vec++;

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], i);
        end

        // Reset while a load waits in REQ, then a stray ack must be ignored.
        @(negedge clk);
        valid = 1'b1; mem_r = 1'b1; funct3 = 3'b010; alu_res = 32'h20;
        @(negedge clk);
        chk("rstreq_inreq", 100, {31'h0, mem_req}, 32'h1);
        rst = 1'b1; idle_inputs();
        @(negedge clk);
        chk("rstreq_req",   100, {31'h0, mem_req}, 32'h0);
        chk("rstreq_stall", 100, {31'h0, stall}, 32'h0);
        chk("rstreq_done",  100, {31'h0, done}, 32'h0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_done", 100 + k, {31'h0, done}, 32'h0);
            chk("stray_req",  100 + k, {31'h0, mem_req}, 32'h0);
        end
        idle_inputs();
        n_vec++;

        // Inputs change during REQ; the latched copy must drive the bus.
        @(negedge clk);
        valid = 1'b1; mem_w = 1'b1; funct3 = 3'b010; alu_res = 32'h80; rs2_data = 32'h1122_3344;
        @(negedge clk);
        alu_res = 32'hFFF; rs2_data = 32'h0; funct3 = 3'b000; mem_w = 1'b0; mem_r = 1'b1;
        #1;
        chk("latch_addr",  200, mem_addr, 32'h80);
        chk("latch_wdata", 200, mem_wdata, 32'h1122_3344);
        chk("latch_be",    200, {28'h0, mem_be}, 32'hF);
        chk("latch_we",    200, {31'h0, mem_we}, 32'h1);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("latch_done",  200, {31'h0, done}, 32'h1);
        chk("latch_err",   200, {30'h0, err}, 32'h0);
        chk("latch_ld",    200, load_data, 32'h0);
        idle_inputs();
        n_vec++;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
